pc_redirect_unit: RTL and testbench

//  Consumer end of the branch-decision path: takes PCSrc (zero & branch from EX) and jump from ID,

---
 rtl/mips_pkg.sv | 27 ++
 rtl/pc_target_calc.sv | 37 +++
 rtl/pc_redirect_unit.sv | 132 +++++++++++++
 tb/tb_pc_redirect_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared types and constants for the PC redirect logic.
//   - ADDR_W_DEFAULT / RESET_PC_DEFAULT : default address width and reset PC
//   - FLUSH_CYCLES_MAX / FCNT_W          : largest flush length and its counter width
//   - pc_state_t                         : fetch FSM state (RUN, FLUSH)
//   - clamp_flush()                      : forces a flush length into 1..FLUSH_CYCLES_MAX
package mips_pkg;

  localparam int          ADDR_W_DEFAULT   = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FLUSH_CYCLES_MAX = 7;
  localparam int          FCNT_W           = 3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pc_state_t;

  // An out-of-range flush length would either never leave FLUSH (0) or overflow
  // the 3-bit counter, so it is pinned to the nearest legal value.
  function automatic int clamp_flush(input int n);
    if (n < 1) return 1;
    if (n > FLUSH_CYCLES_MAX) return FLUSH_CYCLES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc
//   Purely combinational redirect target generation.
//   Ports:
//     ex_pc4     in  ADDR_W  PC+4 of the branch in EX
//     branch_off in  ADDR_W  sign-extended word offset of that branch
//     id_pc4     in  ADDR_W  PC+4 of the jump in ID
//     jump_idx   in  26      instr[25:0] of the jump
//     br_tgt     out ADDR_W  ex_pc4 + offset*4, word aligned
//     j_tgt      out ADDR_W  {id_pc4 top bits, jump_idx, 2'b00}
//   ADDR_W must be at least 29 so the jump keeps at least one region bit.
module pc_target_calc
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [ADDR_W-1:0] ex_pc4,
  input  logic [ADDR_W-1:0] branch_off,
  input  logic [ADDR_W-1:0] id_pc4,
  input  logic [25:0]       jump_idx,
  output logic [ADDR_W-1:0] br_tgt,
  output logic [ADDR_W-1:0] j_tgt
);

  logic [ADDR_W-1:0] br_sum;
  logic              unused_bits;

  // Sum wraps modulo 2^ADDR_W; low two bits are forced to zero afterwards so a
  // misaligned ex_pc4 can never produce a misaligned fetch address.
  assign br_sum = ex_pc4 + (branch_off << 2);
  assign br_tgt = {br_sum[ADDR_W-1:2], 2'b00};

  // Jump stays inside the current region selected by the top PC bits.
  assign j_tgt = {id_pc4[ADDR_W-1:28], jump_idx, 2'b00};

  assign unused_bits = ^{id_pc4[27:0], br_sum[1:0]};

endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Owns the architectural fetch PC, picks the next PC (branch > jump > sequential),
//   and squashes wrong-path fetches for a fixed number of cycles after a redirect.
//   Ports:
//     clk, rst_n             clock and synchronous active-low reset
//     stall                  hold PC (overridden by an accepted redirect)
//     pcsrc, ex_pc4,         taken branch from EX and its operands
//     branch_off
//     jump, id_pc4, jump_idx jump from ID and its operands
//     pc, pc_plus4           current fetch address and its successor
//     if_valid               fetch at pc is on the correct path
//     flush                  squash IF/ID and ID/EX this cycle
//     redirect_cnt           accepted redirects since reset, saturating
module pc_redirect_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                FLUSH_CYCLES = 2,
  parameter int                CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              pcsrc,
  input  logic [ADDR_W-1:0] ex_pc4,
  input  logic [ADDR_W-1:0] branch_off,
  input  logic              jump,
  input  logic [ADDR_W-1:0] id_pc4,
  input  logic [25:0]       jump_idx,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              if_valid,
  output logic              flush,
  output logic [CNT_W-1:0]  redirect_cnt
);

  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(clamp_flush(FLUSH_CYCLES));

  pc_state_t         state_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              flush_q;
  logic              if_valid_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] br_tgt, j_tgt, redirect_tgt, pc_inc;
  logic              accept;

  pc_target_calc #(
    .ADDR_W (ADDR_W)
  ) u_target (
    .ex_pc4     (ex_pc4),
    .branch_off (branch_off),
    .id_pc4     (id_pc4),
    .jump_idx   (jump_idx),
    .br_tgt     (br_tgt),
    .j_tgt      (j_tgt)
  );

  assign pc_inc = pc_q + ADDR_W'(4);

  // Next-PC priority mux. Redirects are only honoured in RUN: anything raised
  // during FLUSH comes from instructions that are being squashed. When both
  // arrive together the branch wins because the jump is younger (wrong path).
  always_comb begin
    accept       = 1'b0;
    redirect_tgt = j_tgt;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    if (state_q == RUN) begin
      accept       = pcsrc | jump;
      redirect_tgt = pcsrc ? br_tgt : j_tgt;
      if (accept) begin
        pc_d = redirect_tgt;
      end else if (!stall) begin
        pc_d = pc_inc;
      end
    end
    if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fetch FSM. PC stays parked on the target throughout FLUSH so its first
  // valid fetch happens in the cycle flush drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fcnt_q     <= '0;
      flush_q    <= 1'b0;
      if_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      case (state_q)
        RUN: begin
          if (accept) begin
            state_q    <= FLUSH;
            fcnt_q     <= FLUSH_LOAD;
            flush_q    <= 1'b1;
            if_valid_q <= 1'b0;
          end else begin
            if_valid_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (fcnt_q <= FCNT_W'(1)) begin
            state_q    <= RUN;
            fcnt_q     <= '0;
            flush_q    <= 1'b0;
            if_valid_q <= 1'b1;
          end else begin
            fcnt_q <= fcnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_inc;
  assign if_valid     = if_valid_q;
  assign flush        = flush_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: a driver applies one cycle of stimulus,
// advances a behavioural model and queues the expected post-edge outputs; a
// monitor pops one entry after each rising edge and compares.
module tb_pc_redirect_unit;

  localparam int FLUSH_CYCLES = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] ex_pc4 = '0;
  logic [31:0] branch_off = '0;
  logic        jump = 1'b0;
  logic [31:0] id_pc4 = '0;
  logic [25:0] jump_idx = '0;
  logic [31:0] pc, pc_plus4;
  logic        if_valid, flush;
  logic [15:0] redirect_cnt;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  int          m_left;   // flush cycles still to be shown
  bit          m_valid;
  int          m_cnt;

  pc_redirect_unit #(
    .ADDR_W       (32),
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .pcsrc        (pcsrc),
    .ex_pc4       (ex_pc4),
    .branch_off   (branch_off),
    .jump         (jump),
    .id_pc4       (id_pc4),
    .jump_idx     (jump_idx),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .if_valid     (if_valid),
    .flush        (flush),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  // One cycle of stimulus plus the model's view of the outputs after the edge.
  task automatic step(input bit r, input bit st, input bit ps, input logic [31:0] ep4,
                      input logic [31:0] bo, input bit jp, input logic [31:0] ip4,
                      input logic [25:0] idx);
    exp_t        e;
    logic [31:0] br, jt;
    @(negedge clk);
    rst_n = r; stall = st; pcsrc = ps; ex_pc4 = ep4; branch_off = bo;
    jump = jp; id_pc4 = ip4; jump_idx = idx;
    br = (ep4 + bo * 32'd4) & 32'hFFFF_FFFC;
    jt = (ip4 & 32'hF000_0000) | ({6'b0, idx} * 32'd4);
    if (!r) begin
      m_pc = 32'h0; m_left = 0; m_valid = 1'b0; m_cnt = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_valid = (m_left == 0);
    end else if (ps || jp) begin
      m_pc    = ps ? br : jt;
      m_left  = FLUSH_CYCLES;
      m_valid = 1'b0;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      if (!st) m_pc = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    e.pc = m_pc; e.flush = (m_left > 0); e.valid = m_valid; e.cnt = m_cnt[15:0];
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, '0, 0, '0, '0);
  endtask

  // Monitor: compare after every rising edge for which an expectation exists.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("cyc=%0d pc=%h flush=%b if_valid=%b cnt=%0d", cyc, pc, flush, if_valid, redirect_cnt);
        check("pc", pc, e.pc);
        check("pc_plus4", pc_plus4, e.pc + 32'd4);
        check("flush", {31'b0, flush}, {31'b0, e.flush});
        check("if_valid", {31'b0, if_valid}, {31'b0, e.valid});
        check("redirect_cnt", {16'b0, redirect_cnt}, {16'b0, e.cnt});
      end
    end
  end

  initial begin
    logic [31:0] r32;
    int          drain;
    // Reset for two cycles, then run sequentially
    step(0, 0, 0, '0, '0, 0, '0, '0);
    step(0, 0, 0, '0, '0, 0, '0, '0);
    idle(3);
    // Jump to 0x40, ride out the flush, then taken branch 0x3C + (-2*4) = 0x34
    step(1, 0, 0, '0, '0, 1, 32'h0, 26'h10);
    idle(2);
    step(1, 0, 1, 32'h3C, 32'hFFFF_FFFE, 0, '0, '0);
    idle(3);
    // Branch (0x100) and jump (0x200) together: branch wins, one count
    step(1, 0, 1, 32'hFC, 32'h1, 1, 32'h0, 26'h80);
    // Redirects in flush cycle 1 and 2 are ignored
    step(1, 0, 1, 32'h500, 32'h4, 1, 32'h0, 26'h300);
    step(1, 0, 0, '0, '0, 1, 32'h0, 26'h300);
    idle(2);
    // Stall three cycles, then stall with a jump (jump wins)
    step(1, 1, 0, '0, '0, 0, '0, '0);
    step(1, 1, 0, '0, '0, 0, '0, '0);
    step(1, 1, 0, '0, '0, 0, '0, '0);
    step(1, 1, 0, '0, '0, 1, 32'h1000_0000, 26'h0000_123);
    step(1, 1, 0, '0, '0, 0, '0, '0);
    step(1, 1, 0, '0, '0, 0, '0, '0);
    idle(2);
    // Wrap: jump to 0xFFFF_FFFC, pc then rolls over to 0
    step(1, 0, 0, '0, '0, 1, 32'hF000_0000, 26'h3FF_FFFF);
    idle(4);
    // Reset mid-flush drops the pending state
    step(1, 0, 1, 32'h2000, 32'h10, 0, '0, '0);
    step(0, 0, 0, '0, '0, 0, '0, '0);
    idle(3);
    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      r32 = $urandom;
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), $urandom, {{16{r32[15]}}, r32[15:0]},
           ($urandom_range(0, 7) == 0), $urandom, 26'($urandom));
    end
    // Let the monitor consume what is left, bounded
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      #2;
      drain++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
